// File: rtl/phase_sequencer_pkg.sv
// Shared phase-state encoding for the multi-cycle core sequencer and anything that decodes its state.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE      = 3'd0,
    STATE_FETCH     = 3'd1,
    STATE_DECODE    = 3'd2,
    STATE_EXECUTE   = 3'd3,
    STATE_MEMORY    = 3'd4,
    STATE_WRITEBACK = 3'd5
  } state_e;

  // Successor of a mid-instruction phase; WRITEBACK's exit depends on run/halt and is handled by the caller.
  function automatic state_e next_phase(input state_e s);
    state_e n;
    n = STATE_IDLE;
    case (s)
      STATE_FETCH:   n = STATE_DECODE;
      STATE_DECODE:  n = STATE_EXECUTE;
      STATE_EXECUTE: n = STATE_MEMORY;
      STATE_MEMORY:  n = STATE_WRITEBACK;
      default:       n = STATE_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phase_sequencer_stall_watchdog.sv
// Counts consecutive stalled cycles of the active phase; pulses abort on the WDT_LIMIT-th one
// and keeps a sticky timeout flag until cleared (a same-cycle set beats the clear).
module stall_watchdog #(
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic stall_i,
  input  logic wdt_clr_i,
  output logic abort_o,
  output logic timeout_o
);

  localparam int unsigned RW = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
  localparam logic [RW-1:0] LAST = RW'((WDT_LIMIT == 0) ? 0 : WDT_LIMIT - 1);
  localparam bit ENABLED = (WDT_LIMIT != 0);

  logic [RW-1:0] stall_run_q, stall_run_d;
  logic          timeout_q, timeout_d;

  assign abort_o   = ENABLED && active_i && stall_i && (stall_run_q == LAST);
  assign timeout_o = timeout_q;

  always_comb begin
    stall_run_d = '0;
    if (ENABLED && active_i && stall_i && !abort_o) begin
      stall_run_d = stall_run_q + RW'(1);
    end
    timeout_d = abort_o | (timeout_q & ~wdt_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Sequences fetch/decode/execute/memory/writeback one-hot enables, holding a phase while its stage stalls;
// counts active cycles and retired instructions and returns to IDLE on halt/run-drop or watchdog abort.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_req_i,
  input  logic                 halt_req_i,
  input  logic                 stall_fetch_i,
  input  logic                 stall_decode_i,
  input  logic                 stall_execute_i,
  input  logic                 stall_memoryaccess_i,
  input  logic                 stall_writeback_i,
  input  logic                 wdt_clr_i,
  output logic                 phase_fetch_o,
  output logic                 phase_decode_o,
  output logic                 phase_execute_o,
  output logic                 phase_memoryaccess_o,
  output logic                 phase_writeback_o,
  output logic                 running_o,
  output logic                 wdt_timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;
  logic                 stage_stall;
  logic                 active;
  logic                 abort;

  assign active = (state_q != STATE_IDLE);

  // Only the stall of the stage owning the current phase matters.
  always_comb begin
    stage_stall = 1'b0;
    case (state_q)
      STATE_FETCH:     stage_stall = stall_fetch_i;
      STATE_DECODE:    stage_stall = stall_decode_i;
      STATE_EXECUTE:   stage_stall = stall_execute_i;
      STATE_MEMORY:    stage_stall = stall_memoryaccess_i;
      STATE_WRITEBACK: stage_stall = stall_writeback_i;
      default:         stage_stall = 1'b0;
    endcase
  end

  stall_watchdog #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_stall_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  (active),
    .stall_i   (stage_stall),
    .wdt_clr_i (wdt_clr_i),
    .abort_o   (abort),
    .timeout_o (wdt_timeout_o)
  );

  always_comb begin
    state_d       = state_q;
    instret_cnt_d = instret_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    if (active) begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    end
    case (state_q)
      STATE_IDLE: begin
        if (run_req_i && !halt_req_i && !wdt_timeout_o) begin
          state_d = STATE_FETCH;
        end
      end
      STATE_WRITEBACK: begin
        if (!stage_stall) begin
          instret_cnt_d = instret_cnt_q + CNT_WIDTH'(1);
          state_d       = (halt_req_i || !run_req_i) ? STATE_IDLE : STATE_FETCH;
        end
      end
      default: begin
        if (!stage_stall) begin
          state_d = next_phase(state_q);
        end
      end
    endcase
    // A hung stage abandons the instruction; abort only fires while stalled, so no retire is lost.
    if (abort) begin
      state_d = STATE_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= STATE_IDLE;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign phase_fetch_o        = (state_q == STATE_FETCH);
  assign phase_decode_o       = (state_q == STATE_DECODE);
  assign phase_execute_o      = (state_q == STATE_EXECUTE);
  assign phase_memoryaccess_o = (state_q == STATE_MEMORY);
  assign phase_writeback_o    = (state_q == STATE_WRITEBACK);
  assign running_o            = active;
  assign cycle_cnt_o          = cycle_cnt_q;
  assign instret_cnt_o        = instret_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed table, multi-cycle corner sequences, then random traffic vs. a phase-index model.
module tb_phase_sequencer;

  localparam int CNT_W = 4;
  localparam int WDT   = 8;
  localparam int MOD   = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             halt = 1'b0;
  logic [4:0]       stl = 5'b0;
  logic             clr = 1'b0;
  logic             ph_f, ph_d, ph_e, ph_m, ph_w;
  logic             running, timeout;
  logic [CNT_W-1:0] cyc, ret;

  int errors = 0;
  int checks = 0;

  // Model: phase index 0=idle,1..5=F..W; integer counters reduced modulo 2^CNT_W.
  int m_ph = 0, m_run = 0, m_cyc = 0, m_ret = 0;
  bit m_to = 1'b0;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_WIDTH(CNT_W), .WDT_LIMIT(WDT)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .run_req_i           (run),
    .halt_req_i          (halt),
    .stall_fetch_i       (stl[0]),
    .stall_decode_i      (stl[1]),
    .stall_execute_i     (stl[2]),
    .stall_memoryaccess_i(stl[3]),
    .stall_writeback_i   (stl[4]),
    .wdt_clr_i           (clr),
    .phase_fetch_o       (ph_f),
    .phase_decode_o      (ph_d),
    .phase_execute_o     (ph_e),
    .phase_memoryaccess_o(ph_m),
    .phase_writeback_o   (ph_w),
    .running_o           (running),
    .wdt_timeout_o       (timeout),
    .cycle_cnt_o         (cyc),
    .instret_cnt_o       (ret)
  );

  function automatic logic [4:0] ph_vec(input int ph);
    logic [4:0] v;
    v = 5'b0;
    if (ph != 0) v[ph-1] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nph, nrun;
    bit  set;
    nph  = m_ph;
    nrun = 0;
    set  = 1'b0;
    if (rst) begin
      m_ph = 0; m_run = 0; m_to = 1'b0; m_cyc = 0; m_ret = 0;
      return;
    end
    if (m_ph != 0) m_cyc = (m_cyc + 1) % MOD;
    if (m_ph == 0) begin
      if (run && !halt && !m_to) nph = 1;
    end else if (stl[m_ph-1]) begin
      if (WDT != 0 && m_run == WDT - 1) begin
        set = 1'b1;
        nph = 0;
      end else begin
        nrun = m_run + 1;
      end
    end else if (m_ph == 5) begin
      m_ret = (m_ret + 1) % MOD;
      nph   = (halt || !run) ? 0 : 1;
    end else begin
      nph = m_ph + 1;
    end
    m_to  = set | (m_to & ~clr);
    m_ph  = nph;
    m_run = nrun;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; halt = 1'b0; stl = 5'b0; clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] dut_ph();
    return {ph_w, ph_m, ph_e, ph_d, ph_f};
  endfunction

  typedef struct {
    logic       run;
    logic       halt;
    logic [4:0] stl;
    int         ph;
    int         cyc;
    int         ret;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int cnt;
    int hang;

    // Execute stall x4 (decode stall alongside is ignored), then halt raised in DECODE.
    tbl[0]  = '{1'b1, 1'b0, 5'b00000, 1,  0, 0};
    tbl[1]  = '{1'b1, 1'b0, 5'b00000, 2,  1, 0};
    tbl[2]  = '{1'b1, 1'b0, 5'b00000, 3,  2, 0};
    tbl[3]  = '{1'b1, 1'b0, 5'b00110, 3,  3, 0};
    tbl[4]  = '{1'b1, 1'b0, 5'b00110, 3,  4, 0};
    tbl[5]  = '{1'b1, 1'b0, 5'b00110, 3,  5, 0};
    tbl[6]  = '{1'b1, 1'b0, 5'b00110, 3,  6, 0};
    tbl[7]  = '{1'b1, 1'b0, 5'b00010, 4,  7, 0};
    tbl[8]  = '{1'b0, 1'b0, 5'b00000, 5,  8, 0};
    tbl[9]  = '{1'b0, 1'b0, 5'b00000, 0,  9, 1};
    tbl[10] = '{1'b0, 1'b0, 5'b00000, 0,  9, 1};
    tbl[11] = '{1'b1, 1'b0, 5'b00000, 1,  9, 1};
    tbl[12] = '{1'b1, 1'b0, 5'b00000, 2, 10, 1};
    tbl[13] = '{1'b1, 1'b1, 5'b00000, 3, 11, 1};
    tbl[14] = '{1'b1, 1'b1, 5'b00000, 4, 12, 1};
    tbl[15] = '{1'b1, 1'b1, 5'b00000, 5, 13, 1};
    tbl[16] = '{1'b1, 1'b1, 5'b00000, 0, 14, 2};
    tbl[17] = '{1'b1, 1'b1, 5'b00000, 0, 14, 2};
    tbl[18] = '{1'b1, 1'b0, 5'b00000, 1, 14, 2};

    do_reset();
    chk("reset_phase", dut_ph(), 5'b0);
    chk("reset_running", running, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_cycle", cyc, 0);
    chk("reset_instret", ret, 0);

    for (int i = 0; i < 19; i++) begin
      run = tbl[i].run; halt = tbl[i].halt; stl = tbl[i].stl;
      tick();
      chk($sformatf("tbl%0d_phase", i), dut_ph(), ph_vec(tbl[i].ph));
      chk($sformatf("tbl%0d_running", i), running, (tbl[i].ph != 0));
      chk($sformatf("tbl%0d_cycle", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_instret", i), ret, tbl[i].ret);
    end
    halt = 1'b0; stl = 5'b0;

    // Three stall-free instructions, run dropped during the third writeback.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("b2b_phase%0d", i), dut_ph(), ph_vec(i % 5 + 1));
      if (i == 14) run = 1'b0;
    end
    tick();
    chk("b2b_idle", dut_ph(), 5'b0);
    chk("b2b_instret", ret, 3);
    chk("b2b_cycle", cyc, 15);

    // Watchdog: memory stage hangs.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("wdt_in_mem", dut_ph(), ph_vec(4));
    stl[3] = 1'b1;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ph_m) break;
      cnt++;
    end
    chk("wdt_mem_cycles", cnt, WDT);
    chk("wdt_timeout_set", timeout, 1);
    chk("wdt_idle", running, 0);
    chk("wdt_no_retire", ret, 0);
    stl = 5'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("wdt_run_ignored", running, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("wdt_cleared", timeout, 0);
    chk("wdt_clr_edge_idle", running, 0);
    tick();
    chk("wdt_restart", dut_ph(), ph_vec(1));
    for (int i = 0; i < 3; i++) tick();
    stl[3] = 1'b1;
    for (int i = 0; i < WDT; i++) begin
      clr = (i == WDT - 1);
      tick();
    end
    clr = 1'b0; stl = 5'b0;
    chk("wdt_set_beats_clr", timeout, 1);
    chk("wdt_second_idle", running, 0);

    // Reset landing in the MEMORY cycle.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_in_mem", dut_ph(), ph_vec(4));
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    chk("rst_mid_phase", dut_ph(), 5'b0);
    chk("rst_mid_running", running, 0);
    chk("rst_mid_instret", ret, 0);
    chk("rst_mid_cycle", cyc, 0);
    tick();
    chk("rst_mid_after", ret, 0);

    // 17 instructions wrap the 4-bit retire counter.
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 84; i++) tick();
    chk("wrap_last_wb", dut_ph(), ph_vec(5));
    run = 1'b0;
    tick();
    chk("wrap_instret", ret, 1);
    chk("wrap_cycle", cyc, 85 % MOD);

    // Random traffic against the model, with occasional hang bursts to reach the watchdog.
    do_reset();
    hang = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      run  = ($urandom_range(0, 9) != 0);
      halt = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      if (hang > 0) begin
        stl  = 5'b11111;
        hang = hang - 1;
      end else if ($urandom_range(0, 49) == 0) begin
        hang = 12;
        stl  = 5'b11111;
      end else begin
        for (int b = 0; b < 5; b++) stl[b] = ($urandom_range(0, 3) == 0);
      end
      tick();
      chk("rnd_phase", dut_ph(), ph_vec(m_ph));
      chk("rnd_running", running, (m_ph != 0));
      chk("rnd_timeout", timeout, m_to);
      chk("rnd_cycle", cyc, m_cyc);
      chk("rnd_instret", ret, m_ret);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
